// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: sample stream, result stream and FIR core port bundle
interface fir_seq_ctrl_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [1:0]       core_operation;
    logic [31:0]      core_addr;
    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_y;
    logic             core_done;
    modport master (
        input  in_valid, in_data, out_ready, core_y, core_done,
        output in_ready, out_valid, out_data, out_last, core_operation, core_addr, core_x
    );
    modport slave (
        output in_valid, in_data, out_ready, core_y, core_done,
        input  in_ready, out_valid, out_data, out_last, core_operation, core_addr, core_x
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: loads samples into a FIR core, runs it under a timeout, streams results out
module fir_seq_ctrl #(
    parameter int SIGNAL_COUNT = 10,
    parameter int WIDTH        = 32,
    parameter int TIMEOUT      = 1024
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           err_timeout,
    fir_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, LOAD_HOLD, COMPUTE, RD_ADDR, RD_DATA, RD_OUT} state_t;
    localparam logic [31:0] LAST     = 32'(SIGNAL_COUNT - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
    state_t           state, state_n;
    logic [31:0]      cnt, cnt_n, tmo, tmo_n, addr_n;
    logic             busy_n, err_n, in_ready_n, out_valid_n, out_last_n;
    logic [WIDTH-1:0] out_data_n, core_x_n;
    logic [1:0]       op_n;
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        tmo_n       = tmo;
        err_n       = err_timeout;
        in_ready_n  = bus.in_ready;
        out_valid_n = bus.out_valid;
        out_last_n  = bus.out_last;
        out_data_n  = bus.out_data;
        core_x_n    = bus.core_x;
        op_n        = bus.core_operation;
        addr_n      = bus.core_addr;
        case (state)
            IDLE: if (start) begin
                state_n    = LOAD;
                err_n      = 1'b0;
                cnt_n      = '0;
                addr_n     = '0;
                core_x_n   = '0;
                op_n       = 2'b01;
                in_ready_n = 1'b1;
            end
            LOAD: if (bus.in_valid && bus.in_ready) begin
                core_x_n = bus.in_data;
                addr_n   = cnt;
                cnt_n    = cnt + 1;
                if (cnt == LAST) begin
                    in_ready_n = 1'b0;
                    state_n    = LOAD_HOLD;
                end
            end
            LOAD_HOLD: begin
                state_n = COMPUTE;
                tmo_n   = '0;
                op_n    = 2'b10;
            end
            COMPUTE: begin
                tmo_n = tmo + 1;
                // done has priority over an expiring timeout in the same cycle
                if (bus.core_done) begin
                    state_n = RD_ADDR;
                    cnt_n   = '0;
                    addr_n  = '0;
                    op_n    = 2'b11;
                end else if (tmo == TMO_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                    op_n    = 2'b00;
                end
            end
            RD_ADDR: state_n = RD_DATA;
            RD_DATA: begin
                out_data_n  = bus.core_y;
                out_valid_n = 1'b1;
                out_last_n  = cnt == LAST;
                state_n     = RD_OUT;
            end
            RD_OUT: if (bus.out_ready) begin
                out_valid_n = 1'b0;
                out_last_n  = 1'b0;
                if (bus.out_last) begin
                    state_n = IDLE;
                    op_n    = 2'b00;
                end else begin
                    cnt_n   = cnt + 1;
                    addr_n  = cnt + 1;
                    state_n = RD_ADDR;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            tmo                <= '0;
            busy               <= 1'b0;
            err_timeout        <= 1'b0;
            bus.in_ready       <= 1'b0;
            bus.out_valid      <= 1'b0;
            bus.out_data       <= '0;
            bus.out_last       <= 1'b0;
            bus.core_operation <= 2'b00;
            bus.core_addr      <= '0;
            bus.core_x         <= '0;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            tmo                <= tmo_n;
            busy               <= busy_n;
            err_timeout        <= err_n;
            bus.in_ready       <= in_ready_n;
            bus.out_valid      <= out_valid_n;
            bus.out_data       <= out_data_n;
            bus.out_last       <= out_last_n;
            bus.core_operation <= op_n;
            bus.core_addr      <= addr_n;
            bus.core_x         <= core_x_n;
        end
    end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: randomized runs against a FIR core model with y[k] = x[k] + 1
module tb_fir_seq_ctrl;
    logic clk, reset, start_a, start_b, busy_a, err_a, busy_b, err_b;
    logic clr_mem, done_en, done_force;
    logic [31:0] mem_a [10];
    logic [31:0] mem_b, last_x;
    int cmp_cnt, hold_seen, n_chk, n_fail;
    fir_seq_ctrl_if #(.WIDTH(32)) a ();
    fir_seq_ctrl_if #(.WIDTH(32)) b ();
    fir_seq_ctrl #(.SIGNAL_COUNT(10), .WIDTH(32), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .err_timeout(err_a), .bus(a.master)
    );
    fir_seq_ctrl #(.SIGNAL_COUNT(1), .WIDTH(32), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .err_timeout(err_b), .bus(b.master)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // core models: write on op 01, registered read on op 11, done a few cycles into compute
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int k = 0; k < 10; k++) mem_a[k] <= 32'hdead_beef;
            hold_seen <= 0;
        end else begin
            if (a.core_operation == 2'b01 && a.core_addr < 10) mem_a[a.core_addr[3:0]] <= a.core_x;
            if (a.core_operation == 2'b01 && a.core_addr == 9 && a.core_x == last_x) hold_seen <= hold_seen + 1;
        end
        if (a.core_operation == 2'b11) a.core_y <= mem_a[a.core_addr[3:0]] + 1;
        cmp_cnt <= (a.core_operation == 2'b10) ? cmp_cnt + 1 : 0;
        if (b.core_operation == 2'b01 && b.core_addr == 0) mem_b <= b.core_x;
        if (b.core_operation == 2'b11) b.core_y <= mem_b + 1;
    end
    assign a.core_done = done_force | (done_en && cmp_cnt >= 5);
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic run_a(input int iv_mode, input int or_pct, input bit rnd, input int bp_idx, input bit timing);
        logic [31:0] s [10];
        int idx = 0, oidx = 0, cyc, bp = 0, last_hs = 0;
        for (int k = 0; k < 10; k++) s[k] = rnd ? $urandom : 32'(k + 1);
        last_x = s[9];
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 1;
        check("start_busy", busy_a, 1);
        check("start_err_clear", err_a, 0);
        check("start_op", a.core_operation, 2'b01);
        check("start_in_ready", a.in_ready, 1);
        while (oidx < 10 && cyc < 400) begin
            a.in_valid = idx < 10 && (iv_mode == 0 ? 1'b1 : iv_mode == 1 ? (cyc % 3 == 1) : $urandom_range(1) == 1);
            a.in_data = idx < 10 ? s[idx] : 32'h0;
            if (a.in_valid && a.in_ready) idx++;
            a.out_ready = $urandom_range(99) < or_pct;
            if (a.out_valid) begin
                if (oidx == bp_idx && bp < 4) begin
                    a.out_ready = 1'b0;
                    check("bp_data", a.out_data, 32'(s[oidx] + 1));
                    check("bp_addr", a.core_addr, oidx);
                    bp++;
                end
                if (a.out_ready) begin
                    if (timing) check("rate", oidx == 0 ? cyc : cyc - last_hs, oidx == 0 ? 20 : 3);
                    check("data", a.out_data, 32'(s[oidx] + 1));
                    check("last", a.out_last, oidx == 9);
                    last_hs = cyc;
                    oidx++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        a.in_valid = 1'b0;
        a.out_ready = 1'b0;
        check("results_in_budget", oidx, 10);
        check("end_busy", busy_a, 0);
        check("end_out_valid", a.out_valid, 0);
        for (int k = 0; k < 10; k++) check("core_mem", mem_a[k], s[k]);
        check("last_sample_written", hold_seen >= 1, 1);
    endtask
    initial begin
        logic [31:0] vb;
        int n10, cyc;
        bit saw_ov;
        n_chk = 0; n_fail = 0;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; clr_mem = 1'b0; done_en = 1'b1; done_force = 1'b0;
        a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0; b.core_done = 1'b0;
        last_x = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_ctrl", {busy_a, err_a, a.in_ready, a.out_valid, a.out_last, a.core_operation}, 0);
        check("rst_data", {a.out_data, a.core_addr}, 0);
        check("rst_x", a.core_x, 0);
        check("rst_b_busy", busy_b, 0);
        run_a(0, 100, 0, -1, 1);
        run_a(1, 100, 0, -1, 0);
        run_a(0, 100, 0, 2, 0);
        repeat (3) run_a(2, 70, 1, -1, 0);
        // timeout: core never signals done
        done_en = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n10 = 0; saw_ov = 0; cyc = 1;
        while (busy_a && cyc < 100) begin
            a.in_valid = a.in_ready;
            a.in_data = 32'(cyc);
            if (a.core_operation == 2'b10) n10++;
            if (a.out_valid) saw_ov = 1;
            @(negedge clk);
            cyc++;
        end
        a.in_valid = 1'b0;
        check("tmo_cycles", n10, 16);
        check("tmo_err", err_a, 1);
        check("tmo_no_output", saw_ov, 0);
        check("tmo_idle_op", a.core_operation, 2'b00);
        repeat (2) @(negedge clk);
        check("tmo_err_sticky", err_a, 1);
        done_en = 1'b1;
        run_a(0, 100, 1, -1, 0);
        // reset mid-load after four samples
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a.in_valid = 1'b1;
            a.in_data = 32'(100 + k);
            @(negedge clk);
        end
        check("pre_rst_addr", a.core_addr, 3);
        a.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ctrl", {busy_a, err_a, a.in_ready, a.out_valid, a.out_last, a.core_operation}, 0);
        check("midrst_data", {a.out_data, a.core_addr}, 0);
        check("midrst_x", a.core_x, 0);
        run_a(0, 100, 0, -1, 1);
        // single-sample corner on the second instance
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_load_op", b.core_operation, 2'b01);
        start_b = 1'b1;
        b.core_done = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        b.core_done = 1'b0;
        check("b_ignore_op", b.core_operation, 2'b01);
        check("b_ignore_ready", b.in_ready, 1);
        vb = $urandom;
        b.in_valid = 1'b1;
        b.in_data = vb;
        @(negedge clk);
        b.in_valid = 1'b0;
        check("b_hold_x", {b.core_operation, b.in_ready, b.core_x}, {2'b01, 1'b0, vb});
        for (int i = 0; i < 5 && b.core_operation != 2'b10; i++) @(negedge clk);
        check("b_compute", b.core_operation, 2'b10);
        repeat (2) @(negedge clk);
        b.core_done = 1'b1;
        @(negedge clk);
        b.core_done = 1'b0;
        check("b_read_op", {b.core_operation, b.core_addr}, {2'b11, 32'h0});
        for (int i = 0; i < 5 && !b.out_valid; i++) @(negedge clk);
        check("b_out_valid", b.out_valid, 1);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_held", {b.out_valid, b.out_last, busy_b}, 3'b111);
        check("b_data", b.out_data, 32'(vb + 1));
        b.out_ready = 1'b1;
        @(negedge clk);
        b.out_ready = 1'b0;
        check("b_end", {busy_b, b.out_valid, b.out_last}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
